spi_slave_mod: RTL and testbench
================================

// Module: spi_slave_mod
// PURPOSE
//  SPI responder: the far end of the SPI master driven by the control/transfer regs.
//  Oversamples SCLK/SS_n/MOSI in clk_i domain, shifts bytes in/out per CPOL/CPHA/data order.
//  Presents a byte-wide RX strobe and a one-deep TX holding buffer to local logic.
//  Used as on-chip loopback peer and as the bench reference slave for the master path.
// PARAMETERS
//  SYNC_STAGES  2  flops in each pin synchronizer (min 2)
//  DATA_W       8  bits per SPI word
// PORTS
//  clk_i         in   1       system clock; must be >= 4x SCLK frequency
//  reset_i       in   1       synchronous, active-high reset
//  cpol_i        in   1       1: SCLK idles high, 0: idles low
//  cpha_i        in   1       1: leading edge setup/trailing sample, 0: leading sample
//  data_order_i  in   1       1: MSB first, 0: LSB first
//  sclk_i        in   1       SPI clock pin (async)
//  ss_n_i        in   1       slave select pin, active low (async)
//  mosi_i        in   1       master-out data pin (async)
//  miso_o        out  1       slave-out data
//  miso_oe_o     out  1       MISO output enable (1 while selected)
//  tx_data_i     in   DATA_W  next byte to send
//  tx_valid_i    in   1       tx_data_i valid
//  tx_ready_o    out  1       holding buffer empty; transfer on tx_valid_i & tx_ready_o
//  rx_data_o     out  DATA_W  last complete received word
//  rx_valid_o    out  1       one-cycle pulse, rx_data_o updated
//  tx_underrun_o out  1       one-cycle pulse: word load found holding buffer empty
//  busy_o        out  1       frame in progress (synced SS asserted)
// BEHAVIOUR
//  Reset: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0,
//   tx_underrun_o=0, busy_o=0, state IDLE, bit count 0, holding empty; sync flops -> idle (SS_n=1).
//  Sync: each pin via SYNC_STAGES flops; edges = sync output vs 1-cycle delayed copy.
//  FSM IDLE -> ACTIVE on synced SS_n fall; ACTIVE -> IDLE on synced SS_n rise.
//  On IDLE->ACTIVE: latch cpol/cpha/data_order for whole frame (mid-frame changes ignored);
//   load shift reg from holding (else 0, pulse tx_underrun_o); bit count 0; miso_oe_o=1.
//  Leading edge = SCLK leaving latched CPOL level; trailing = returning to it.
//  CPHA=0: first bit on miso_o from frame start; sample on leading, shift out on trailing.
//  CPHA=1: shift out on leading (first bit driven at first leading edge), sample on trailing.
//  Bit order: data_order=1 -> MSB in/out first; 0 -> LSB first (both directions).
//  Sample edge increments bit count; on DATA_W-th sample: rx_data_o <= assembled word,
//   rx_valid_o pulse next cycle (SYNC_STAGES+1 clk_i after pin edge), count wraps to 0,
//   next word loaded from holding (else 0 + tx_underrun_o); CPHA=0 drives its MSB/LSB now.
//  Holding: tx_ready_o = !hold_full. Load into shift reg and tx_valid accept in same cycle:
//   load takes old content, hold stays empty for that cycle's accept only if tx_ready_o was 1.
//  SS_n rise mid-word: partial word discarded, no rx_valid_o, count 0, miso_oe_o=0 next cycle;
//   the shifted-out word is lost, holding buffer retained.
//  SCLK edges while IDLE ignored. Reset mid-frame: all state to reset values immediately.
//  rx_valid_o has no backpressure; consumer must take it in the pulse cycle.
// STRUCTURE
//  Shared include spi_defs.vh: FSM state encodings (IDLE/ACTIVE), DATA_W default, config bit
//   indices matching control reg (div 7:0, order 8, CPOL 9, CPHA 10).
//  Sub-module sync_edge_det: SYNC_STAGES synchronizer + rise/fall pulse outputs; one instance
//   each for sclk_i and ss_n_i; mosi_i uses plain synchronizer (same depth, aligned).
// TESTING
//  Mode0 (cpol0 cpha0 MSB), tx 0xA5 preloaded, master sends 0x3C -> rx_data_o=0x3C, MISO=0xA5.
//  Mode3 LSB first, master sends 0x01 then 0x80 in one frame -> two rx_valid_o, 0x01 then 0x80.
//  No tx_valid before frame -> tx_underrun_o pulse at SS fall, MISO bits all 0, rx still valid.
//  SS_n rises after 5 bits of 0xFF -> no rx_valid_o, next frame 0x55 received cleanly.
//  Flip cpol_i mid-frame (mode1) -> current frame unaffected, master 0xC3 received as 0xC3.
//  reset_i pulse after 3 bits -> outputs at reset values, tx_ready_o=1, next frame correct.

Source files
------------

// File: rtl/spi_slave_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_mod_pkg
// Description : Shared types and default sizes for the SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_mod_pkg;

    localparam int c_DEF_DATA_W      = 8;
    localparam int c_DEF_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage : spi_slave_mod_pkg
`default_nettype wire

// File: rtl/spi_slave_mod_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_mod_sync_edge_det
// Description : Multi-flop pin synchronizer with rise/fall pulse outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_mod_sync_edge_det
    import spi_slave_mod_pkg::*;
#(
    parameter int   SYNC_STAGES = c_DEF_SYNC_STAGES,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_dly  <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_dly;
    assign o_fall  = ~o_level & r_dly;

endmodule : spi_slave_mod_sync_edge_det
`default_nettype wire

// File: rtl/spi_slave_mod.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_mod
// Description : Oversampling SPI responder with RX strobe and one-deep TX buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_mod
    import spi_slave_mod_pkg::*;
#(
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES,
    parameter int DATA_W      = c_DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              data_order_i,
    input  logic              sclk_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int                c_CNT_W   = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DATA_W - 1);

    state_t r_state, w_state_nxt;

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic w_mosi;

    logic r_cpol, r_cpha, r_order;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_tx_shift, r_rx_shift, r_hold, r_rx_data;
    logic r_hold_full, r_miso, r_miso_oe, r_rx_valid, r_underrun;

    spi_slave_mod_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_pin   (sclk_i),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_slave_mod_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ss (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_pin   (ss_n_i),
        .o_level (w_ss_level),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // Same depth as the edge detectors so MOSI lines up with the SCLK edge pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_mosi_sync <= '0;
        else         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_ss_fall) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_ss_rise) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    logic w_start, w_stop, w_edge, w_lead, w_trail, w_sample, w_shift, w_last;
    logic w_load, w_accept, w_order_now, w_load_bit, w_shift_bit, w_out_cur;
    logic [DATA_W-1:0] w_load_word, w_rx_next, w_tx_shifted;

    assign w_start  = (r_state == ST_IDLE) && w_ss_fall;
    assign w_stop   = (r_state == ST_ACTIVE) && w_ss_rise;
    assign w_edge   = (r_state == ST_ACTIVE) && !w_ss_rise && (w_sclk_rise || w_sclk_fall);
    assign w_lead   = w_edge && (w_sclk_level != r_cpol);
    assign w_trail  = w_edge && (w_sclk_level == r_cpol);
    assign w_sample = r_cpha ? w_trail : w_lead;
    // CPHA=0: the trailing edge right after a word boundary must not disturb the freshly loaded word.
    assign w_shift  = r_cpha ? w_lead : (w_trail && (r_bit_cnt != '0));
    assign w_last   = w_sample && (r_bit_cnt == c_CNT_MAX);
    assign w_load   = w_start || w_last;
    assign w_accept = tx_valid_i && !r_hold_full;

    assign w_order_now  = w_start ? data_order_i : r_order;
    assign w_load_word  = r_hold_full ? r_hold : '0;
    assign w_load_bit   = w_order_now ? w_load_word[DATA_W-1] : w_load_word[0];
    assign w_out_cur    = r_order ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
    assign w_shift_bit  = r_order ? r_tx_shift[DATA_W-2] : r_tx_shift[1];
    assign w_tx_shifted = r_order ? {r_tx_shift[DATA_W-2:0], 1'b0} : {1'b0, r_tx_shift[DATA_W-1:1]};
    assign w_rx_next    = r_order ? {r_rx_shift[DATA_W-2:0], w_mosi} : {w_mosi, r_rx_shift[DATA_W-1:1]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_order     <= 1'b0;
            r_bit_cnt   <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= w_load && !r_hold_full;

            if (w_accept) begin
                r_hold      <= tx_data_i;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_start) begin
                r_cpol     <= cpol_i;
                r_cpha     <= cpha_i;
                r_order    <= data_order_i;
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= w_load_word;
                r_miso     <= cpha_i ? 1'b0 : w_load_bit;
                r_miso_oe  <= 1'b1;
            end else if (w_stop) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (w_last) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    end
                end

                if (w_last) begin
                    r_tx_shift <= w_load_word;
                    if (!r_cpha) r_miso <= w_load_bit;
                end else if (w_shift) begin
                    r_tx_shift <= w_tx_shifted;
                    r_miso     <= r_cpha ? w_out_cur : w_shift_bit;
                end
            end
        end
    end

    assign miso_o        = r_miso;
    assign miso_oe_o     = r_miso_oe;
    assign tx_ready_o    = ~r_hold_full;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_underrun_o = r_underrun;
    assign busy_o        = ~w_ss_level;

endmodule : spi_slave_mod
`default_nettype wire

// File: tb/tb_spi_slave_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_mod
// Description : Directed self-checking bench acting as SPI master for spi_slave_mod.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_mod;

    localparam time HALF = 80ns;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       cpol_i = 1'b0, cpha_i = 1'b0, data_order_i = 1'b1;
    logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic       miso_o, miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, busy_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic [7:0] rx_data_o;

    int total = 0;
    int bad   = 0;

    logic       m_cpol, m_cpha, m_order;
    logic [7:0] m_mi;
    logic [7:0] mi_a;
    int         rx_cnt = 0;
    int         n_under = 0;
    logic [7:0] rx_log [0:63];
    int         rx_base, un_base;

    always #5 clk = ~clk;

    spi_slave_mod u_dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .cpol_i        (cpol_i),
        .cpha_i        (cpha_i),
        .data_order_i  (data_order_i),
        .sclk_i        (sclk),
        .ss_n_i        (ss_n),
        .mosi_i        (mosi),
        .miso_o        (miso_o),
        .miso_oe_o     (miso_oe_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always @(negedge clk) begin
        if (rx_valid_o === 1'b1) begin
            rx_log[rx_cnt & 63] <= rx_data_o;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_underrun_o === 1'b1) n_under <= n_under + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic cp, input logic ph, input logic ord);
        cpol_i = cp; cpha_i = ph; data_order_i = ord;
        m_cpol = cp; m_cpha = ph; m_order = ord;
        sclk = cp;
        repeat (4) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'd0, tx_ready_o}, 32'd1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic frame_begin();
        un_base = n_under;
        rx_base = rx_cnt;
        m_mi = 8'h00;
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        #HALF;
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] mo, input int first, input int last_b);
        int idx;
        for (int i = first; i <= last_b; i++) begin
            idx = m_order ? 7 - i : i;
            if (!m_cpha) begin
                mosi = mo[idx];
                #HALF;
                sclk = ~m_cpol;
                m_mi[idx] = miso_o;
                #HALF;
                sclk = m_cpol;
            end else begin
                #HALF;
                sclk = ~m_cpol;
                mosi = mo[idx];
                #HALF;
                m_mi[idx] = miso_o;
                sclk = m_cpol;
            end
        end
    endtask

    initial begin
        m_cpol = 1'b0; m_cpha = 1'b0; m_order = 1'b1; m_mi = 8'h00; mi_a = 8'h00;
        rx_base = 0; un_base = 0;
        repeat (4) @(negedge clk);
        chk("rst_miso",    {31'd0, miso_o},        32'd0);
        chk("rst_oe",      {31'd0, miso_oe_o},     32'd0);
        chk("rst_ready",   {31'd0, tx_ready_o},    32'd1);
        chk("rst_rxdata",  {24'd0, rx_data_o},     32'd0);
        chk("rst_rxvalid", {31'd0, rx_valid_o},    32'd0);
        chk("rst_under",   {31'd0, tx_underrun_o}, 32'd0);
        chk("rst_busy",    {31'd0, busy_o},        32'd0);
        reset_i = 1'b0;

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b1);
        push(8'hA5);
        chk("m0_hold_full", {31'd0, tx_ready_o}, 32'd0);
        frame_begin();
        chk("m0_busy", {31'd0, busy_o},    32'd1);
        chk("m0_oe",   {31'd0, miso_oe_o}, 32'd1);
        chk("m0_ready_after_load", {31'd0, tx_ready_o}, 32'd1);
        xfer_bits(8'h3C, 0, 7);
        frame_end();
        chk("m0_rx_cnt", rx_cnt - rx_base, 32'd1);
        chk("m0_rx",     {24'd0, rx_log[rx_base & 63]}, 32'h3C);
        chk("m0_miso",   {24'd0, m_mi}, 32'hA5);
        chk("m0_under",  n_under - un_base, 32'd1);
        chk("m0_oe_off", {31'd0, miso_oe_o}, 32'd0);
        chk("m0_busy_off", {31'd0, busy_o}, 32'd0);

        // Mode 3, LSB first, two words in one frame
        set_mode(1'b1, 1'b1, 1'b0);
        push(8'h96);
        frame_begin();
        push(8'h3A);
        xfer_bits(8'h01, 0, 7);
        mi_a = m_mi;
        xfer_bits(8'h80, 0, 7);
        frame_end();
        chk("m3_rx_cnt", rx_cnt - rx_base, 32'd2);
        chk("m3_rx0",    {24'd0, rx_log[rx_base & 63]}, 32'h01);
        chk("m3_rx1",    {24'd0, rx_log[(rx_base + 1) & 63]}, 32'h80);
        chk("m3_miso0",  {24'd0, mi_a}, 32'h96);
        chk("m3_miso1",  {24'd0, m_mi}, 32'h3A);
        chk("m3_under",  n_under - un_base, 32'd1);

        // Underrun: nothing queued before the frame
        set_mode(1'b0, 1'b0, 1'b1);
        frame_begin();
        chk("ur_at_start", n_under - un_base, 32'd1);
        xfer_bits(8'h5A, 0, 7);
        frame_end();
        chk("ur_miso",   {24'd0, m_mi}, 32'h00);
        chk("ur_rx_cnt", rx_cnt - rx_base, 32'd1);
        chk("ur_rx",     {24'd0, rx_log[rx_base & 63]}, 32'h5A);
        chk("ur_total",  n_under - un_base, 32'd2);

        // Abort after 5 bits, then a clean frame
        frame_begin();
        xfer_bits(8'hFF, 0, 4);
        frame_end();
        chk("ab_no_rx", rx_cnt - rx_base, 32'd0);
        chk("ab_oe_off", {31'd0, miso_oe_o}, 32'd0);
        push(8'h0F);
        frame_begin();
        xfer_bits(8'h55, 0, 7);
        frame_end();
        chk("ab_rx_cnt", rx_cnt - rx_base, 32'd1);
        chk("ab_rx",     {24'd0, rx_log[rx_base & 63]}, 32'h55);
        chk("ab_miso",   {24'd0, m_mi}, 32'h0F);

        // Mode 1 with cpol_i flipped mid-frame
        set_mode(1'b0, 1'b1, 1'b1);
        push(8'hE7);
        frame_begin();
        xfer_bits(8'hC3, 0, 3);
        cpol_i = 1'b1;
        xfer_bits(8'hC3, 4, 7);
        frame_end();
        chk("cf_rx_cnt", rx_cnt - rx_base, 32'd1);
        chk("cf_rx",     {24'd0, rx_log[rx_base & 63]}, 32'hC3);
        chk("cf_miso",   {24'd0, m_mi}, 32'hE7);
        cpol_i = 1'b0;

        // Reset pulse mid-frame
        set_mode(1'b0, 1'b0, 1'b1);
        push(8'h81);
        frame_begin();
        xfer_bits(8'hFF, 0, 2);
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_oe",      {31'd0, miso_oe_o},  32'd0);
        chk("mr_miso",    {31'd0, miso_o},     32'd0);
        chk("mr_ready",   {31'd0, tx_ready_o}, 32'd1);
        chk("mr_rxdata",  {24'd0, rx_data_o},  32'd0);
        chk("mr_busy",    {31'd0, busy_o},     32'd0);
        ss_n = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("mr_no_rx", rx_cnt - rx_base, 32'd0);
        push(8'h42);
        frame_begin();
        xfer_bits(8'h99, 0, 7);
        frame_end();
        chk("mr_rx_cnt", rx_cnt - rx_base, 32'd1);
        chk("mr_rx",     {24'd0, rx_log[rx_base & 63]}, 32'h99);
        chk("mr_miso",   {24'd0, m_mi}, 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_slave_mod
`default_nettype wire
